// File: rtl/cipher_stream_ctrl.sv
// Sequences the LFSR/S-box/P-box cipher datapath: accepts samples, drives load/step/enable strobes, re-seeds per frame.
// Latency PIPE_DEPTH cycles from accept to out_valid; an output stall freezes the whole pipeline and deasserts in_ready.
module cipher_stream_ctrl #(
    parameter int FRAME_LEN  = 256,
    parameter int PIPE_DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] key,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       pipe_en,
    output logic       lfsr_load,
    output logic [7:0] lfsr_seed,
    output logic       lfsr_step,
    output logic [7:0] frame_idx,
    output logic       frame_done,
    output logic       busy
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_REKEY,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PIPE_DEPTH-1:0] r_vld;
    logic [PIPE_DEPTH-1:0] w_vld_nxt;
    logic [CNT_W-1:0]      r_sample_cnt;
    logic [7:0]            r_frame_idx;
    logic [7:0]            r_key_q;
    logic [7:0]            r_lfsr_seed;
    logic                  r_stop_pend;

    logic                  w_out_valid;
    logic                  w_pipe_en;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_frame_end;
    logic [7:0]            w_frame_nxt;

    // An all-zero seed would lock the LFSR in its zero state.
    function automatic logic [7:0] guard_seed(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    assign w_out_valid = r_vld[PIPE_DEPTH-1];
    assign w_pipe_en   = (r_state != S_IDLE) && (!w_out_valid || out_ready);
    assign w_in_ready  = (r_state == S_RUN) && w_pipe_en && !r_stop_pend;
    assign w_accept    = in_valid && w_in_ready;
    assign w_frame_end = w_accept && (r_sample_cnt == LAST_CNT);
    assign w_frame_nxt = r_frame_idx + 8'd1;

    always_comb begin
        w_vld_nxt = r_vld;
        if (w_pipe_en) begin
            w_vld_nxt[0] = w_accept;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                w_vld_nxt[i] = r_vld[i-1];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SEED;
            S_SEED:  w_state_nxt = (r_stop_pend || stop) ? S_DRAIN : S_RUN;
            S_RUN: begin
                if (w_frame_end)  w_state_nxt = S_REKEY;
                else if (stop)    w_state_nxt = S_DRAIN;
            end
            S_REKEY: w_state_nxt = (r_stop_pend || stop) ? S_DRAIN : S_RUN;
            S_DRAIN: if (w_vld_nxt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_vld        <= '0;
            r_sample_cnt <= '0;
            r_frame_idx  <= 8'h00;
            r_key_q      <= 8'h00;
            r_lfsr_seed  <= 8'h00;
            r_stop_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vld   <= w_vld_nxt;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_key_q      <= key;
                    r_frame_idx  <= 8'h00;
                    r_sample_cnt <= '0;
                    r_lfsr_seed  <= guard_seed(key);
                    r_stop_pend  <= stop;
                end
            end else begin
                // Frame bookkeeping advances on the closing accept so REKEY already shows the new frame.
                if (w_frame_end) begin
                    r_frame_idx  <= w_frame_nxt;
                    r_sample_cnt <= '0;
                    r_lfsr_seed  <= guard_seed(r_key_q ^ w_frame_nxt);
                end else if (w_accept) begin
                    r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                end
                if (r_state == S_DRAIN && w_state_nxt == S_IDLE) begin
                    r_stop_pend <= 1'b0;
                end else if (stop) begin
                    r_stop_pend <= 1'b1;
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign pipe_en    = w_pipe_en;
    assign lfsr_load  = (r_state == S_SEED) || (r_state == S_REKEY);
    assign lfsr_seed  = r_lfsr_seed;
    assign lfsr_step  = w_accept;
    assign frame_idx  = r_frame_idx;
    assign frame_done = (r_state == S_REKEY);
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// Bench for cipher_stream_ctrl: a behavioural LFSR/S-box/P-box datapath follows the DUT strobes,
// and a frame/position model predicts every encrypted byte independently of the controller.
module tb_cipher_stream_ctrl;

    localparam int FL = 4;
    localparam int PD = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, in_valid, out_ready;
    logic [7:0] key, in_dat;
    logic       in_ready, out_valid, pipe_en, lfsr_load, lfsr_step, frame_done, busy;
    logic [7:0] lfsr_seed, frame_idx;

    cipher_stream_ctrl #(.FRAME_LEN(FL), .PIPE_DEPTH(PD)) dut (
        .clk(clk), .rst(rst_n), .start(start), .stop(stop), .key(key),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .pipe_en(pipe_en), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_step(lfsr_step),
        .frame_idx(frame_idx), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] m;
        m = x * 8'd37;
        return m + 8'd11;
    endfunction
    function automatic logic [7:0] pbox(input logic [7:0] x);
        return {x[4:0], x[7:5]};
    endfunction
    function automatic logic [7:0] model_ks(input logic [7:0] k, input logic [7:0] f, input int p);
        logic [7:0] s;
        s = k ^ f;
        if (s == 8'h00) s = 8'h01;
        for (int i = 0; i < p; i++) s = lfsr_next(s);
        return s;
    endfunction

    // Datapath stand-in driven purely by the controller strobes.
    logic [7:0] tb_lfsr, tb_d0, tb_d1, tb_d2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_lfsr <= 8'h00; tb_d0 <= 8'h00; tb_d1 <= 8'h00; tb_d2 <= 8'h00;
        end else begin
            if (lfsr_load)      tb_lfsr <= lfsr_seed;
            else if (lfsr_step) tb_lfsr <= lfsr_next(tb_lfsr);
            if (pipe_en) begin
                tb_d0 <= in_dat ^ tb_lfsr;
                tb_d1 <= sbox(tb_d0);
                tb_d2 <= pbox(tb_d1);
            end
        end
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] mkey, mframe;
    int mpos;

    logic snap_in_ready, snap_out_valid, snap_pipe_en, snap_load, snap_step, snap_fd, snap_busy;
    logic snap_acc, snap_hs;
    logic [7:0] snap_seed, snap_fidx, snap_dat;
    int snap_cyc, last_hs_cyc, fd_cnt, both_cnt;

    // One clock cycle: inputs already driven; sample mid-cycle, record handshakes, advance.
    task automatic tick();
        #2;
        snap_in_ready = in_ready; snap_out_valid = out_valid; snap_pipe_en = pipe_en;
        snap_load = lfsr_load; snap_step = lfsr_step; snap_fd = frame_done; snap_busy = busy;
        snap_seed = lfsr_seed; snap_fidx = frame_idx; snap_dat = tb_d2; snap_cyc = cyc;
        snap_acc = in_valid && in_ready;
        snap_hs  = out_valid && out_ready;
        if (frame_done) fd_cnt++;
        if (lfsr_load && lfsr_step) both_cnt++;
        if (snap_acc) begin
            exp_q.push_back(pbox(sbox(in_dat ^ model_ks(mkey, mframe, mpos))));
            mpos++;
            if (mpos == FL) begin
                mpos = 0;
                mframe = mframe + 8'd1;
            end
        end
        if (snap_hs) begin
            got_q.push_back(tb_d2);
            last_hs_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_session(input logic [7:0] k);
        exp_q.delete(); got_q.delete();
        mkey = k; mframe = 8'h00; mpos = 0;
        fd_cnt = 0; both_cnt = 0;
        key = k; start = 1'b1; stop = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(output logic timed_out);
        int n;
        stop = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        stop = 1'b0;
        n = 0;
        while (snap_busy && n < 60) begin
            tick();
            n++;
        end
        timed_out = snap_busy;
    endtask

    task automatic test_reset();
        logic [7:0] z8 = 8'h00;
        total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (pipe_en !== 1'b0)    begin bad++; $display("FAIL reset_pipe_en got=%b want=0", pipe_en); end
        total++; if (lfsr_load !== 1'b0)  begin bad++; $display("FAIL reset_lfsr_load got=%b want=0", lfsr_load); end
        total++; if (lfsr_step !== 1'b0)  begin bad++; $display("FAIL reset_lfsr_step got=%b want=0", lfsr_step); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (lfsr_seed !== z8)    begin bad++; $display("FAIL reset_lfsr_seed got=%h want=00", lfsr_seed); end
        total++; if (frame_idx !== z8)    begin bad++; $display("FAIL reset_frame_idx got=%h want=00", frame_idx); end
    endtask

    task automatic test_basic_stream();
        int acc_cyc, n;
        logic to;
        start_session(8'h5A);
        in_valid = 1'b1; out_ready = 1'b1; in_dat = 8'($urandom);
        tick();
        total++; if (snap_load !== 1'b1 || snap_seed !== 8'h5A)
            begin bad++; $display("FAIL basic_seed load=%b seed=%h want load=1 seed=5a", snap_load, snap_seed); end
        total++; if (snap_in_ready !== 1'b0) begin bad++; $display("FAIL basic_seed_ready got=%b want=0", snap_in_ready); end
        in_dat = 8'($urandom);
        tick();
        total++; if (snap_in_ready !== 1'b1) begin bad++; $display("FAIL basic_first_ready got=%b want=1", snap_in_ready); end
        acc_cyc = snap_cyc;
        n = 0;
        do begin
            in_dat = 8'($urandom);
            tick();
            n++;
        end while (!snap_out_valid && n < 20);
        total++; if (snap_cyc - acc_cyc !== PD)
            begin bad++; $display("FAIL basic_latency got=%0d want=%0d", snap_cyc - acc_cyc, PD); end
        n = 0;
        while (got_q.size() < 10 && n < 60) begin
            in_dat = 8'($urandom);
            tick();
            n++;
        end
        drain(to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_drain_timeout got=%b want=0", to); end
        total++; if (got_q.size() !== exp_q.size() || got_q.size() < 10)
            begin bad++; $display("FAIL basic_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i])
                begin bad++; $display("FAIL basic_data[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL basic_load_step_overlap got=%0d want=0", both_cnt); end
    endtask

    task automatic test_frame_boundary(input logic [7:0] k, input logic [7:0] want_seed);
        int n, acc;
        logic to;
        start_session(k);
        in_valid = 1'b1; out_ready = 1'b1; in_dat = 8'($urandom);
        tick();
        acc = 0; n = 0;
        while (acc < FL && n < 20) begin
            in_dat = 8'($urandom);
            tick();
            if (snap_acc) acc++;
            n++;
        end
        in_dat = 8'($urandom);
        tick();
        total++; if (snap_fd !== 1'b1 || snap_fidx !== 8'h01)
            begin bad++; $display("FAIL rekey_%h frame_done=%b frame_idx=%h want 1/01", k, snap_fd, snap_fidx); end
        total++; if (snap_load !== 1'b1 || snap_seed !== want_seed)
            begin bad++; $display("FAIL rekey_seed_%h load=%b seed=%h want 1/%h", k, snap_load, snap_seed, want_seed); end
        total++; if (snap_in_ready !== 1'b0) begin bad++; $display("FAIL rekey_gap_%h got=%b want=0", k, snap_in_ready); end
        in_dat = 8'($urandom);
        tick();
        total++; if (snap_in_ready !== 1'b1 || snap_fd !== 1'b0)
            begin bad++; $display("FAIL rekey_resume_%h ready=%b fd=%b want 1/0", k, snap_in_ready, snap_fd); end
        for (int i = 0; i < 3; i++) begin
            in_dat = 8'($urandom);
            tick();
        end
        drain(to);
        total++; if (to !== 1'b0 || got_q.size() !== 8 || exp_q.size() !== 8)
            begin bad++; $display("FAIL frame_count_%h got=%0d want=8 timeout=%b", k, got_q.size(), to); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i])
                begin bad++; $display("FAIL frame_data_%h[%0d] got=%h want=%h", k, i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int n, acc;
        logic [7:0] held;
        logic to;
        start_session(8'($urandom));
        in_valid = 1'b1; out_ready = 1'b1; in_dat = 8'($urandom);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (snap_acc) acc++;
            in_dat = 8'($urandom);
        end
        out_ready = 1'b0;
        n = 0;
        do begin
            in_valid = (acc < 20) ? 1'b1 : 1'b0;
            in_dat = 8'($urandom);
            tick();
            if (snap_acc) acc++;
            n++;
        end while (!snap_out_valid && n < 10);
        held = snap_dat;
        for (int i = 0; i < 5; i++) begin
            in_valid = (acc < 20) ? 1'($urandom) : 1'b0;
            in_dat = 8'($urandom);
            tick();
            if (snap_acc) acc++;
            total++; if (snap_out_valid !== 1'b1 || snap_pipe_en !== 1'b0)
                begin bad++; $display("FAIL bp_hold[%0d] out_valid=%b pipe_en=%b want 1/0", i, snap_out_valid, snap_pipe_en); end
            total++; if (snap_in_ready !== 1'b0 || snap_step !== 1'b0)
                begin bad++; $display("FAIL bp_gate[%0d] in_ready=%b step=%b want 0/0", i, snap_in_ready, snap_step); end
            total++; if (snap_dat !== held)
                begin bad++; $display("FAIL bp_stable[%0d] got=%h want=%h", i, snap_dat, held); end
        end
        n = 0;
        while (acc < 20 && n < 300) begin
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            in_dat = 8'($urandom);
            tick();
            if (snap_acc) acc++;
            n++;
        end
        drain(to);
        total++; if (to !== 1'b0 || exp_q.size() !== 20 || got_q.size() !== 20)
            begin bad++; $display("FAIL bp_count in=%0d out=%0d want 20/20 timeout=%b", exp_q.size(), got_q.size(), to); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i])
                begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_stop();
        int n, ready_bad;
        start_session(8'($urandom));
        in_valid = 1'b1; out_ready = 1'b1; in_dat = 8'($urandom);
        tick();
        in_dat = 8'($urandom);
        tick();
        fd_cnt = 0;
        stop = 1'b1; in_dat = 8'($urandom);
        tick();
        total++; if (snap_acc !== 1'b1) begin bad++; $display("FAIL stop_accept got=%b want=1", snap_acc); end
        stop = 1'b0;
        ready_bad = 0; n = 0;
        do begin
            in_dat = 8'($urandom);
            tick();
            if (snap_in_ready) ready_bad++;
            n++;
        end while (snap_busy && n < 30);
        in_valid = 1'b0;
        total++; if (ready_bad !== 0) begin bad++; $display("FAIL stop_ready_after got=%0d want=0", ready_bad); end
        total++; if (got_q.size() !== 2 || exp_q.size() !== 2)
            begin bad++; $display("FAIL stop_count got=%0d want=2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i])
                begin bad++; $display("FAIL stop_data[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        total++; if (snap_busy !== 1'b0 || snap_cyc !== last_hs_cyc + 1)
            begin bad++; $display("FAIL stop_busy_drop busy=%b cyc=%0d want 0 at %0d", snap_busy, snap_cyc, last_hs_cyc + 1); end
        total++; if (fd_cnt !== 0 || snap_fidx !== 8'h00)
            begin bad++; $display("FAIL stop_partial fd=%0d frame_idx=%h want 0/00", fd_cnt, snap_fidx); end
    endtask

    task automatic test_async_reset();
        int n, acc, seen;
        start_session(8'($urandom));
        in_valid = 1'b1; out_ready = 1'b0; in_dat = 8'($urandom);
        tick();
        acc = 0; n = 0;
        while (acc < 3 && n < 10) begin
            in_dat = 8'($urandom);
            tick();
            if (snap_acc) acc++;
            n++;
        end
        in_valid = 1'b0;
        tick();
        total++; if (snap_out_valid !== 1'b1 || snap_busy !== 1'b1)
            begin bad++; $display("FAIL arst_pre out_valid=%b busy=%b want 1/1", snap_out_valid, snap_busy); end
        rst_n = 1'b0;
        #1;
        total++; if ({in_ready, out_valid, pipe_en, lfsr_load, lfsr_step, frame_done, busy} !== 7'b0)
            begin bad++; $display("FAIL arst_outputs got=%b want=0000000",
                {in_ready, out_valid, pipe_en, lfsr_load, lfsr_step, frame_done, busy}); end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        got_q.delete(); exp_q.delete();
        in_valid = 1'b1; out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            in_dat = 8'($urandom);
            tick();
            if (snap_out_valid || snap_busy || snap_in_ready) seen++;
        end
        in_valid = 1'b0;
        total++; if (seen !== 0 || got_q.size() !== 0)
            begin bad++; $display("FAIL arst_after activity=%0d outputs=%0d want 0/0", seen, got_q.size()); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; key = 8'h00;
        in_valid = 1'b0; in_dat = 8'h00; out_ready = 1'b0;
        mkey = 8'h00; mframe = 8'h00; mpos = 0;
        last_hs_cyc = 0; fd_cnt = 0; both_cnt = 0;
        @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        tick();
        tick();
        test_basic_stream();
        test_frame_boundary(8'h03, 8'h02);
        test_frame_boundary(8'h01, 8'h01);
        test_backpressure();
        test_stop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cipher_stream_ctrl.md
# cipher_stream_ctrl

Sequencing controller for the 8-bit audio block-cipher datapath (LFSR keystream XOR stage, S-box stage, P-box stage). It accepts samples from the audio source over a valid/ready handshake and generates the LFSR load/step and pipeline-enable strobes. It tracks in-flight samples, presents encrypted samples downstream with valid/ready backpressure, and re-seeds the keystream at every frame boundary.

## Interface
Parameters:
- FRAME_LEN, 256: samples per frame before re-key (≥2).
- PIPE_DEPTH, 3: datapath register stages from accept to encrypted output.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin session (sampled in IDLE only).
- stop  in  1  end session after draining.
- key  in  8  session key; captured on accepted start.
- in_valid  in  1  source has a sample.
- in_ready  out  1  controller accepts sample this cycle.
- out_valid  out  1  encrypted sample valid at datapath output.
- out_ready  in  1  sink takes sample.
- pipe_en  out  1  advance all datapath registers.
- lfsr_load  out  1  load lfsr_seed into LFSR this cycle.
- lfsr_seed  out  8  seed value, registered.
- lfsr_step  out  1  advance LFSR one state.
- frame_idx  out  8  current frame number.
- frame_done  out  1  one-cycle pulse at frame completion.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, SEED, RUN, REKEY, DRAIN.
- Internal valid shift register vld[PIPE_DEPTH-1:0] mirrors the datapath; out_valid = vld[PIPE_DEPTH-1].
- pipe_en = (state ≠ IDLE) && (!out_valid || out_ready). When pipe_en=1, vld shifts: vld[0] ← accept, vld[i] ← vld[i-1]. When pipe_en=0, vld holds.
- in_ready = (state == RUN) && pipe_en && !stop_pend. accept = in_valid && in_ready. lfsr_step = accept.
- Seed formula: s = key_q ^ frame_idx. lfsr_seed = (s == 0) ? 8'h01 : s. The substitution prevents LFSR lockup.
- IDLE → SEED on start: capture key_q, clear frame_idx and sample_cnt.
- SEED (1 cycle): lfsr_load=1 → RUN, or → DRAIN if stop is pending.
- RUN: on each accept, sample_cnt++. The accept that brings sample_cnt to FRAME_LEN → REKEY.
- RUN: stop=1 sets stop_pend. If the cycle also accepts, that sample is kept. → DRAIN next cycle.
- REKEY (1 cycle): frame_idx++ (8-bit wrap 255→0), sample_cnt←0, frame_done=1, lfsr_load=1 with the seed from the new frame_idx; in_ready=0. → RUN, or → DRAIN if stop_pend.
- In-flight samples are unaffected by re-key: the keystream is consumed at accept.
- DRAIN: in_ready=0; pipeline keeps advancing under pipe_en. When vld == 0 → IDLE, clear stop_pend.
- start outside IDLE is ignored. stop in IDLE is ignored. start and stop in the same IDLE cycle → SEED, with stop_pend set.
- Partial frame at stop: frame_done is not pulsed and frame_idx is not incremented.

## Timing
- Reset (rst=0, asynchronous): state IDLE, vld=0, sample_cnt=0, frame_idx=0, key_q=0, lfsr_seed=0, stop_pend=0.
- Reset output values: in_ready, out_valid, pipe_en, lfsr_load, lfsr_step, frame_done, busy all 0.
- Reset mid-operation discards in-flight samples; no output handshake completes.
- start at cycle T: SEED at T+1 (lfsr_load=1); RUN at T+2 with in_ready=1 if the sink is not stalling.
- Latency: a sample accepted at cycle T gives out_valid=1 at T+PIPE_DEPTH with no stall. Each cycle with pipe_en=0 adds one cycle.
- Throughput: 1 sample/cycle in RUN. Exactly one bubble per frame (the REKEY cycle).
- Backpressure: when out_valid=1 and out_ready=0, pipe_en=0, in_ready=0, and all vld bits hold. Output data stays stable.
- lfsr_load and lfsr_step are never asserted in the same cycle.

## Test plan
- **Basic stream:** reset, key=8'h5A, start, in_valid held high, out_ready=1.
  - SEED lfsr_seed=8'h5A.
  - First in_ready at start+2; first out_valid 3 cycles after first accept.
  - Check 10 outputs against the golden cipher model.
- **Frame boundary:** FRAME_LEN=4, key=8'h03, continuous input.
  - REKEY after the 4th accept, with frame_done=1 and frame_idx=1.
  - lfsr_seed=8'h02 on the load cycle; one-cycle in_ready gap.
  - Second frame's outputs match the model.
- **Zero-seed guard:** key=8'h01, FRAME_LEN=4; run into frame 1.
  - key^1=0, so lfsr_seed=8'h01 on that REKEY.
- **Backpressure:** hold out_ready=0 for 5 cycles while out_valid=1.
  - pipe_en=0, in_ready=0, no lfsr_step, output byte stable.
  - On release, no sample is lost or duplicated; count 20 in = 20 out.
- **Stop handling:** assert stop with an accept in the same RUN cycle.
  - That sample emerges; in_ready=0 afterwards; busy drops 1 cycle after the last out_valid handshake.
  - No frame_done for the partial frame.
- **Async reset mid-stream:** pull rst low during RUN with 3 samples in flight.
  - All outputs 0 immediately; after release, IDLE with no out_valid until a new start.
